// File: rtl/response_encoder_pkg.sv
// Shared protocol definitions for the UART response path: frame layout,
// FSM encodings and the frame checksum.
package response_encoder_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN    = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd3;
  localparam logic [2:0] ST_NEXT      = 3'd4;

  // Byte 0 sits in the lowest lane, byte 3 (checksum) in the highest.
  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  // 8-bit wrapping sum of the three payload bytes.
  function automatic logic [7:0] checksum(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2);
    logic [7:0] sum;
    sum = b0 + b1;
    sum = sum + b2;
    return sum;
  endfunction

  // Assemble a complete frame from the request fields.
  function automatic frame_t build_frame(input logic [7:0] sync,
                                         input logic [7:0] cmd,
                                         input logic [2:0] status);
    frame_t f;
    f[0] = sync;
    f[1] = cmd;
    f[2] = {5'b00000, status};
    f[3] = checksum(f[0], f[1], f[2]);
    return f;
  endfunction

endpackage

// File: rtl/response_encoder.sv
// Builds a 4-byte response frame (sync, cmd, LED status, checksum) and
// streams it into uart_tx using the send/busy handshake. One extra request
// can be held pending while a frame is in flight.
module response_encoder
  import response_encoder_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] cmd,
  input  logic [2:0] status,
  input  logic       snd_busy,
  output logic [7:0] snd_data,
  output logic       snd_ready,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       timeout_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT);

  logic [2:0] state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  frame_t     frame, frame_n;
  frame_t     pend_frame, pend_frame_n;
  logic       pend_valid, pend_valid_n;
  frame_t     new_frame;

  logic [7:0] data_n;
  logic       ready_n, busy_n, done_n, ovf_n, tmo_n;

  // Next-state, datapath and output-strobe decode for the frame sequencer.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    frame_n      = frame;
    pend_frame_n = pend_frame;
    pend_valid_n = pend_valid;
    data_n       = snd_data;
    ready_n      = 1'b0;
    done_n       = 1'b0;
    ovf_n        = 1'b0;
    tmo_n        = 1'b0;
    new_frame    = build_frame(SYNC_BYTE, cmd, status);

    case (state)
      ST_IDLE: begin
        if (req) begin
          frame_n = new_frame;
          idx_n   = 2'd0;
          state_n = ST_SEND;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEND: begin
        ready_n = 1'b1;
        data_n  = frame[idx];
        cnt_n   = 8'd1;
        state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (snd_busy) begin
          state_n = ST_WAIT_IDLE;
        end else if (cnt >= TIMEOUT_LAST) begin
          tmo_n   = 1'b1;
          state_n = ST_NEXT;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_WAIT_IDLE: begin
        // No timeout here: a stuck transmitter stalls the encoder.
        if (!snd_busy) begin
          state_n = ST_NEXT;
        end else begin
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_NEXT: begin
        if (idx != 2'd3) begin
          idx_n   = idx + 2'd1;
          state_n = ST_SEND;
        end else begin
          done_n = 1'b1;
          if (pend_valid) begin
            frame_n      = pend_frame;
            pend_valid_n = 1'b0;
            idx_n        = 2'd0;
            state_n      = ST_SEND;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Requests outside IDLE go to the pending slot; checking the already
    // updated valid bit lets a request reuse a slot freed this same cycle.
    if (req && (state != ST_IDLE)) begin
      if (!pend_valid_n) begin
        pend_frame_n = new_frame;
        pend_valid_n = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end else begin
      ovf_n = 1'b0;
    end

    busy_n = (state_n != ST_IDLE) | pend_valid_n;
  end

  // State, frame storage and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      cnt         <= 8'd0;
      frame       <= '0;
      pend_frame  <= '0;
      pend_valid  <= 1'b0;
      snd_data    <= 8'd0;
      snd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      frame       <= frame_n;
      pend_frame  <= pend_frame_n;
      pend_valid  <= pend_valid_n;
      snd_data    <= data_n;
      snd_ready   <= ready_n;
      busy        <= busy_n;
      done        <= done_n;
      overflow    <= ovf_n;
      timeout_err <= tmo_n;
    end
  end

endmodule

// File: tb/tb_response_encoder.sv
// Scoreboard bench for response_encoder: stimulus pushes hand-computed frame
// bytes into a queue, a monitor pops and compares on every snd_ready.
module tb_response_encoder;

  logic       clk = 1'b0;
  logic       reset, req, snd_busy;
  logic [7:0] cmd;
  logic [2:0] status;
  logic [7:0] snd_data;
  logic       snd_ready, busy, done, overflow, timeout_err;

  int checks = 0, errors = 0;
  int cyc = 0, ready_cnt = 0, done_cnt = 0, ovf_cnt = 0, tmo_cnt = 0;
  int ready_cyc[$], done_cyc[$], tmo_cyc[$];
  logic [7:0] exp_q[$];
  logic bus_en;
  int   bcnt;

  response_encoder #(.BUSY_TIMEOUT(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd), .status(status),
    .snd_busy(snd_busy), .snd_data(snd_data), .snd_ready(snd_ready),
    .busy(busy), .done(done), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus model: busy rises 2 cycles after the send pulse and holds 10 cycles.
  initial begin
    snd_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (reset || !bus_en) begin
        bcnt = 0;
        snd_busy = 1'b0;
      end else if (bcnt == 0) begin
        if (snd_ready) bcnt = 1;
      end else begin
        bcnt++;
        snd_busy = (bcnt >= 3 && bcnt < 13);
        if (bcnt == 13) bcnt = 0;
      end
    end
  end

  // Monitor: compares each presented byte against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b0) begin
        if (snd_ready) begin
          ready_cnt++;
          ready_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_send: got byte %0h with empty scoreboard", snd_data);
          end else begin
            check("frame_byte", {24'd0, snd_data}, {24'd0, exp_q.pop_front()});
          end
        end
        if (done) begin done_cnt++; done_cyc.push_back(cyc); end
        if (overflow) ovf_cnt++;
        if (timeout_err) begin tmo_cnt++; tmo_cyc.push_back(cyc); end
      end
    end
  end

  task automatic send_req(input logic [7:0] c, input logic [2:0] s);
    @(posedge clk); #1;
    req = 1'b1; cmd = c; status = s;
    @(posedge clk); #1;
    req = 1'b0; cmd = 8'h00; status = 3'b000;  // later changes must not matter
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0); exp_q.push_back(b1);
    exp_q.push_back(b2); exp_q.push_back(b3);
  endtask

  task automatic wait_ready(input int n);
    int w = 0;
    while (ready_cnt < n && w < 500) begin @(negedge clk); w++; end
    check("wait_ready", {31'd0, ready_cnt >= n}, 32'd1);
  endtask

  task automatic wait_done(input int n);
    int w = 0;
    while (done_cnt < n && w < 500) begin @(negedge clk); w++; end
    check("wait_done", {31'd0, done_cnt >= n}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int rb, db, ob, tb, w;
    reset = 1'b1; req = 1'b0; cmd = 8'h00; status = 3'b000; bus_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {19'd0, snd_ready, busy, done, overflow, timeout_err, snd_data}, 32'd0);

    // Single frame with latency check.
    rb = ready_cnt; db = done_cnt;
    push_frame(8'hA5, 8'h52, 8'h05, 8'hFC);
    send_req(8'h52, 3'b101);
    @(negedge clk);
    check("ready_not_yet", {31'd0, snd_ready}, 32'd0);
    @(negedge clk);
    check("ready_first", {31'd0, snd_ready}, 32'd1);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    wait_done(db + 1);
    idle(3);
    check("frame1_sends", ready_cnt - rb, 32'd4);
    check("frame1_done", done_cnt - db, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back frames plus an overflowing third request.
    rb = ready_cnt; db = done_cnt; ob = ovf_cnt;
    push_frame(8'hA5, 8'h52, 8'h05, 8'hFC);
    send_req(8'h52, 3'b101);
    wait_ready(rb + 2);
    push_frame(8'hA5, 8'h47, 8'h02, 8'hEE);
    send_req(8'h47, 3'b010);
    send_req(8'h33, 3'b011);
    wait_done(db + 2);
    idle(40);
    check("overflow_pulses", ovf_cnt - ob, 32'd1);
    check("two_frames_sends", ready_cnt - rb, 32'd8);
    check("two_frames_done", done_cnt - db, 32'd2);
    if (ready_cyc.size() > rb + 4 && done_cyc.size() > db)
      check("b2b_gap", ready_cyc[rb + 4] - done_cyc[db], 32'd1);
    else
      check("b2b_gap_present", 32'd0, 32'd1);
    check("queue_empty_b2b", exp_q.size(), 32'd0);

    // Timeout path: busy never rises.
    bus_en = 1'b0;
    rb = ready_cnt; db = done_cnt; tb = tmo_cnt;
    push_frame(8'hA5, 8'h10, 8'h01, 8'hB6);
    send_req(8'h10, 3'b001);
    wait_done(db + 1);
    idle(3);
    check("timeout_pulses", tmo_cnt - tb, 32'd4);
    if (tmo_cyc.size() >= tb + 4 && ready_cyc.size() > rb) begin
      check("timeout_first", tmo_cyc[tb] - ready_cyc[rb], 32'd16);
      for (int i = 0; i < 3; i++)
        check("timeout_spacing", tmo_cyc[tb + i + 1] - tmo_cyc[tb + i], 32'd18);
    end else begin
      check("timeout_records", 32'd0, 32'd1);
    end
    check("timeout_done", done_cnt - db, 32'd1);
    bus_en = 1'b1;

    // Reset during WAIT_IDLE of byte 2.
    rb = ready_cnt;
    push_frame(8'hA5, 8'h52, 8'h05, 8'hFC);
    send_req(8'h52, 3'b101);
    wait_ready(rb + 3);
    w = 0;
    while (snd_busy !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("busy_seen", {31'd0, snd_busy}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset_outputs", {19'd0, snd_ready, busy, done, overflow, timeout_err, snd_data}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    rb = ready_cnt;
    idle(30);
    check("no_send_after_reset", ready_cnt - rb, 32'd0);

    // Clean frame after reset, also exercising checksum wrap.
    db = done_cnt;
    push_frame(8'hA5, 8'hFF, 8'h07, 8'hAB);
    send_req(8'hFF, 3'b111);
    wait_done(db + 1);
    idle(3);
    check("wrap_sends", ready_cnt - rb, 32'd4);
    check("queue_empty_end", exp_q.size(), 32'd0);
    check("busy_end", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
